eq_band_mix_ctrl: RTL and testbench

Sequencing and mixing controller for the 8-band equalizer. It accepts one input-sample strobe and pulses the enable of all band filters. It waits for the filters to finish, then applies a per-band gain to each band output through one shared multiplier, one band per cycle. It then emits the saturated mixed sample with a valid strobe. Gains are written into shadow registers and take effect atomically on commit, never in the middle of a sample.

---
 rtl/eq_band_mix_ctrl.sv | 160 ++++++++++++++++
 tb/tb_eq_band_mix_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_mix_ctrl.sv
// Equalizer sequencer: strobes band filters, MACs band_y*gain one band per cycle, emits saturated mix.
// Latency: y_valid NBANDS+1 cycles after band_done; strobes arriving while busy are dropped and flagged by overrun.
module eq_band_mix_ctrl #(
  parameter int NBANDS = 8,
  parameter int YW     = 32,
  parameter int GW     = 16,
  parameter int OW     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_in_valid,
  output logic                      band_ena,
  input  logic                      band_done,
  input  logic [NBANDS*YW-1:0]      band_y,
  input  logic                      cfg_we,
  input  logic [$clog2(NBANDS)-1:0] cfg_addr,
  input  logic [GW-1:0]             cfg_gain,
  input  logic                      cfg_commit,
  output logic [OW-1:0]             y_mix,
  output logic                      y_valid,
  output logic                      busy,
  output logic                      overrun
);
  localparam int AW   = $clog2(NBANDS);
  localparam int PW   = YW + GW;
  localparam int ACCW = PW + AW;
  localparam logic [AW-1:0] LAST_K = AW'(NBANDS - 1);
  localparam logic [GW-1:0] UNITY  = GW'(16384);

  typedef enum logic [1:0] {IDLE, FILT, MAC, OUT} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           k_q, k_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [OW-1:0]           y_mix_q, y_mix_d;
  logic                    y_valid_q, y_valid_d;
  logic                    band_ena_q, band_ena_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    pending_q, pending_d;
  logic [GW-1:0]           shadow_q [NBANDS];
  logic [GW-1:0]           shadow_d [NBANDS];
  logic [GW-1:0]           active_q [NBANDS];
  logic [GW-1:0]           active_d [NBANDS];
  logic [YW-1:0]           band_lat_q [NBANDS];
  logic [YW-1:0]           band_lat_d [NBANDS];

  logic signed [YW-1:0]    y_sel;
  logic signed [GW-1:0]    g_sel;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc_sum;
  logic signed [ACCW-1:0]  acc_shr;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    y_mix_d    = y_mix_q;
    y_valid_d  = 1'b0;
    band_ena_d = 1'b0;
    overrun_d  = 1'b0;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    band_lat_d = band_lat_q;

    // Single shared multiplier, addressed by the band index.
    y_sel   = band_lat_q[k_q];
    g_sel   = active_q[k_q];
    prod    = PW'(y_sel) * PW'(g_sel);
    acc_sum = acc_q + ACCW'(prod);
    acc_shr = acc_sum >>> 14;

    if (cfg_we) shadow_d[cfg_addr] = cfg_gain;

    case (state_q)
      IDLE: begin
        if (cfg_commit) active_d = shadow_d;
        if (sample_in_valid) begin
          state_d    = FILT;
          band_ena_d = 1'b1;
          acc_d      = '0;
          k_d        = '0;
        end
      end
      FILT: begin
        if (band_done) begin
          for (int i = 0; i < NBANDS; i++) band_lat_d[i] = band_y[i*YW +: YW];
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == LAST_K) begin
          state_d   = OUT;
          y_valid_d = 1'b1;
          if (!acc_shr[ACCW-1] && (|acc_shr[ACCW-2:OW-1]))
            y_mix_d = {1'b0, {(OW-1){1'b1}}};
          else if (acc_shr[ACCW-1] && !(&acc_shr[ACCW-2:OW-1]))
            y_mix_d = {1'b1, {(OW-1){1'b0}}};
          else
            y_mix_d = acc_shr[OW-1:0];
        end
      end
      OUT: begin
        state_d = IDLE;
        // A commit landing in OUT itself is honoured on this same edge.
        if (pending_q || cfg_commit) active_d = shadow_d;
        pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (sample_in_valid) overrun_d = 1'b1;
      if (cfg_commit && state_q != OUT) pending_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      acc_q      <= '0;
      y_mix_q    <= '0;
      y_valid_q  <= 1'b0;
      band_ena_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      pending_q  <= 1'b0;
      for (int i = 0; i < NBANDS; i++) begin
        shadow_q[i]   <= UNITY;
        active_q[i]   <= UNITY;
        band_lat_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      y_mix_q    <= y_mix_d;
      y_valid_q  <= y_valid_d;
      band_ena_q <= band_ena_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      band_lat_q <= band_lat_d;
    end
  end

  assign y_mix    = y_mix_q;
  assign y_valid  = y_valid_q;
  assign band_ena = band_ena_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_eq_band_mix_ctrl.sv
// Bench for eq_band_mix_ctrl: directed and random samples against an arithmetic reference model.
module tb_eq_band_mix_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_in_valid;
  logic        band_ena;
  logic        band_done;
  logic [255:0] band_y;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_gain;
  logic        cfg_commit;
  logic [31:0] y_mix;
  logic        y_valid;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int yv_cnt = 0, ov_cnt = 0, be_cnt = 0;

  logic [31:0] by  [8];
  logic [15:0] sh  [8];
  logic [15:0] act [8];
  logic [15:0] gv  [8];

  always #5 clk = ~clk;

  eq_band_mix_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sample_in_valid(sample_in_valid), .band_ena(band_ena),
    .band_done(band_done), .band_y(band_y), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_gain(cfg_gain), .cfg_commit(cfg_commit), .y_mix(y_mix), .y_valid(y_valid),
    .busy(busy), .overrun(overrun)
  );

  always_comb begin
    band_y = '0;
    for (int k = 0; k < 8; k++) band_y[k*32 +: 32] = by[k];
  end

  always @(negedge clk) begin
    if (y_valid)  yv_cnt++;
    if (overrun)  ov_cnt++;
    if (band_ena) be_cnt++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mix();
    longint s = 0;
    for (int k = 0; k < 8; k++)
      s += longint'($signed(by[k])) * longint'($signed(act[k]));
    s = s >>> 14;
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return 32'(s);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      sh[k]  = 16'd16384;
      act[k] = 16'd16384;
    end
  endtask

  // Writes all eight shadow gains; the commit rides on the last write.
  task automatic load_gains();
    for (int k = 0; k < 8; k++) begin
      cfg_we     = 1'b1;
      cfg_addr   = 3'(k);
      cfg_gain   = gv[k];
      cfg_commit = (k == 7);
      sh[k]      = gv[k];
      next_cycle();
    end
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    act = sh;
  endtask

  task automatic run_sample(input int dly, input int dup_at, input int cm_at,
                            input logic [15:0] cm_gain, input int rst_at, input string tag);
    logic [31:0] exp;
    int vcyc, yv0, ov0, be0;
    exp  = model_mix();
    vcyc = -1;
    yv0 = yv_cnt; ov0 = ov_cnt; be0 = be_cnt;
    for (int c = 0; c < dly + 14; c++) begin
      if (c == rst_at + 1) rst_n = 1'b1;
      if (y_valid && vcyc < 0) vcyc = c;
      if (c == 1) begin
        chk({tag, "_band_ena"}, 64'(band_ena), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
      end
      sample_in_valid = (c == 0) || (c == dup_at);
      band_done       = (c == dly);
      cfg_we          = (c == cm_at);
      cfg_commit      = (c == cm_at);
      cfg_addr        = 3'd0;
      cfg_gain        = cm_gain;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_ymix"}, 64'(y_mix), 64'd0);
        chk({tag, "_rst_busy"}, 64'(busy), 64'd0);
        model_reset();
      end
      next_cycle();
    end
    sample_in_valid = 1'b0;
    band_done = 1'b0;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    if (rst_at < 0) begin
      chk({tag, "_vcyc"}, 64'(vcyc), 64'(dly + 9));
      chk({tag, "_ymix"}, 64'(y_mix), 64'(exp));
      chk({tag, "_yv_cnt"}, 64'(yv_cnt - yv0), 64'd1);
      if (cm_at >= 0) begin
        sh[0] = cm_gain;
        act = sh;
      end
    end else begin
      chk({tag, "_ymix_after_rst"}, 64'(y_mix), 64'd0);
      chk({tag, "_yv_cnt"}, 64'(yv_cnt - yv0), 64'd0);
    end
    chk({tag, "_be_cnt"}, 64'(be_cnt - be0), 64'd1);
    chk({tag, "_ov_cnt"}, 64'(ov_cnt - ov0), (dup_at >= 0) ? 64'd1 : 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sample_in_valid = 1'b0;
    band_done = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = 3'd0;
    cfg_gain = 16'd0;
    cfg_commit = 1'b0;
    for (int k = 0; k < 8; k++) by[k] = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ymix", 64'(y_mix), 64'd0);
    chk("reset_yvalid", 64'(y_valid), 64'd0);
    chk("reset_band_ena", 64'(band_ena), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    next_cycle();

    // Unity gains after reset
    for (int k = 0; k < 8; k++) by[k] = 32'd1000;
    run_sample(2, -1, -1, 16'd0, -1, "unity");

    // Only band 3 at 0.5
    for (int k = 0; k < 8; k++) begin
      gv[k] = 16'd0;
      by[k] = 32'd5000;
    end
    gv[3] = 16'h2000;
    by[3] = -32'sd2000;
    load_gains();
    run_sample(2, -1, -1, 16'd0, -1, "band3");

    // Saturation both directions
    for (int k = 0; k < 8; k++) begin
      gv[k] = 16'h7FFF;
      by[k] = 32'h7FFFFFFF;
    end
    load_gains();
    run_sample(2, -1, -1, 16'd0, -1, "sat_pos");
    for (int k = 0; k < 8; k++) by[k] = 32'h80000000;
    run_sample(3, -1, -1, 16'd0, -1, "sat_neg");

    // Overrun during MAC, then commit while busy
    for (int k = 0; k < 8; k++) begin
      gv[k] = 16'd16384;
      by[k] = 32'(100 * (k + 1));
    end
    load_gains();
    run_sample(2, 5, -1, 16'd0, -1, "overrun");
    run_sample(3, -1, 1, 16'd0, -1, "cbusy_cur");
    run_sample(2, -1, -1, 16'd0, -1, "cbusy_next");

    // Reset in the fourth MAC cycle, then a clean sample
    run_sample(2, -1, -1, 16'd0, 2 + 4, "rst_mac");
    run_sample(2, -1, -1, 16'd0, -1, "post_rst");

    // Random gains, band outputs and filter latency
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) begin
        gv[k] = 16'($urandom_range(65535, 0));
        by[k] = $urandom();
      end
      load_gains();
      run_sample(int'($urandom_range(5, 2)), -1, -1, 16'd0, -1, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
